// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle FETCH/DECODE/EXECUTE controller for an accumulator machine.
//   Each non-halt instruction takes three cycles. The program counter
//   advances only when EXECUTE hands back to FETCH. HLT parks the sequencer
//   in HALT until reset.
//
// Ports
//   clock_in          : rising-edge clock
//   reset_n_in        : synchronous, active-low reset
//   instr_in          : program memory data, valid one cycle after instr_addr_out
//   zero_indicator_in : ALU zero flag
//   signal_bit_in     : ALU sign flag
//   instr_addr_out    : program counter
//   data_addr_out     : data memory address (IR operand)
//   data_wr_out       : data memory write strobe (EXECUTE of STO)
//   acc_wr_out        : accumulator load strobe
//   acc_src_sel_out   : accumulator source (00 ALU, 01 data memory, 10 immediate)
//   alu_b_sel_out     : ALU B operand (0 data memory, 1 immediate)
//   operation_out     : ALU operation (0 add, 1 subtract)
//   immediate_out     : IR operand sign-extended from bit 10
//   halted_out        : high while halted
module control_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  zero_indicator_in,
    input  logic                  signal_bit_in,
    output logic [ADDR_WIDTH-1:0] instr_addr_out,
    output logic [ADDR_WIDTH-1:0] data_addr_out,
    output logic                  data_wr_out,
    output logic                  acc_wr_out,
    output logic [1:0]            acc_src_sel_out,
    output logic                  alu_b_sel_out,
    output logic                  operation_out,
    output logic [DATA_WIDTH-1:0] immediate_out,
    output logic                  halted_out
);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    typedef enum logic [4:0] {
        OP_HLT  = 5'b00000, OP_STO  = 5'b00001, OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011, OP_ADD  = 5'b00100, OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110, OP_SUBI = 5'b00111, OP_BEQ  = 5'b01000,
        OP_BNE  = 5'b01001, OP_BGT  = 5'b01010, OP_BGE  = 5'b01011,
        OP_BLT  = 5'b01100, OP_BLE  = 5'b01101, OP_JMP  = 5'b01110
    } opcode_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [DATA_WIDTH-1:0] ir;
    logic                  flag_z, flag_n;
    logic                  flag_load;
    logic                  taken;
    logic                  data_wr, acc_wr;
    opcode_t               opcode;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == DECODE) begin
                ir <= instr_in;
            end
            if (flag_load) begin
                flag_z <= zero_indicator_in;
                flag_n <= signal_bit_in;
            end
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        flag_load       = 1'b0;
        taken           = 1'b0;
        data_wr         = 1'b0;
        acc_wr          = 1'b0;
        acc_src_sel_out = 2'b00;
        alu_b_sel_out   = 1'b0;
        operation_out   = 1'b0;
        opcode          = opcode_t'(ir[15:11]);

        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = EXECUTE;
            EXECUTE: begin
                state_next = FETCH;
                pc_next    = pc + 1'b1;
                case (opcode)
                    OP_HLT: begin
                        state_next = HALT;
                        pc_next    = pc;
                    end
                    OP_STO:  data_wr = 1'b1;
                    OP_LD: begin
                        acc_wr          = 1'b1;
                        acc_src_sel_out = 2'b01;
                    end
                    OP_LDI: begin
                        acc_wr          = 1'b1;
                        acc_src_sel_out = 2'b10;
                        alu_b_sel_out   = 1'b1;
                    end
                    OP_ADD: begin
                        acc_wr    = 1'b1;
                        flag_load = 1'b1;
                    end
                    OP_ADDI: begin
                        acc_wr        = 1'b1;
                        alu_b_sel_out = 1'b1;
                        flag_load     = 1'b1;
                    end
                    OP_SUB: begin
                        acc_wr        = 1'b1;
                        operation_out = 1'b1;
                        flag_load     = 1'b1;
                    end
                    OP_SUBI: begin
                        acc_wr        = 1'b1;
                        operation_out = 1'b1;
                        alu_b_sel_out = 1'b1;
                        flag_load     = 1'b1;
                    end
                    OP_BEQ:  taken = flag_z;
                    OP_BNE:  taken = !flag_z;
                    OP_BGT:  taken = !flag_z && !flag_n;
                    OP_BGE:  taken = !flag_n;
                    OP_BLT:  taken = flag_n;
                    OP_BLE:  taken = flag_n || flag_z;
                    OP_JMP:  taken = 1'b1;
                    default: ;
                endcase
                if (taken) begin
                    pc_next = ir[ADDR_WIDTH-1:0];
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Strobes are gated by the live reset so a reset landing in EXECUTE
    // never issues a write in that same cycle.
    assign data_wr_out    = data_wr && reset_n_in;
    assign acc_wr_out     = acc_wr && reset_n_in;
    assign instr_addr_out = pc;
    assign data_addr_out  = ir[ADDR_WIDTH-1:0];
    assign immediate_out  = {{(DATA_WIDTH-11){ir[10]}}, ir[10:0]};
    assign halted_out     = (state == HALT);

endmodule
